// File: rtl/dcache_write_buffer_pkg.sv
// Shared types and constants for the data-cache write-back buffer.
// Derived widths are helper functions so cache and buffer size from one offset value.
package dcache_write_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [3:0] AXI_STRB_FULL  = 4'hF;

    localparam int DEF_OFFSET_LEN = 6;

    function automatic int line_bits(input int offset_len);
        return 1 << (offset_len + 3);
    endfunction

    function automatic int beat_count(input int offset_len);
        return 1 << (offset_len - 2);
    endfunction

    function automatic int count_width(input int offset_len);
        return offset_len - 1;
    endfunction

endpackage

// File: rtl/dcache_write_buffer_mux.sv
// Word-select mux: picks beat i_sel out of a latched cache line, word 0 in the low bits.
module mux_write_data #(
    parameter int LINE_BITS = 512,
    parameter int SEG_W     = 32,
    parameter int SEL_W     = 5
) (
    input  logic [LINE_BITS-1:0] i_line,
    input  logic [SEL_W-1:0]     i_sel,
    output logic [SEG_W-1:0]     o_data
);

    localparam int NUM_WORDS = LINE_BITS / SEG_W;

    always_comb begin
        o_data = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (i_sel == SEL_W'(i)) begin
                o_data = i_line[i*SEG_W +: SEG_W];
            end
        end
    end

endmodule

// File: rtl/dcache_write_buffer.sv
// Single-entry write-back buffer: captures one dirty line in a cycle and drains it
// as a 16-beat INCR burst, flagging address matches against the line in flight.
module dcache_write_buffer
    import dcache_write_buffer_pkg::*;
#(
    parameter int Offset_len    = DEF_OFFSET_LEN,
    parameter int Segment_width = 32,
    parameter int Addr_width    = 32,
    localparam int LINE_BITS    = line_bits(Offset_len),
    localparam int CNT_W        = count_width(Offset_len)
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_wb_req,
    input  logic [Addr_width-1:0]    i_wb_addr,
    input  logic [LINE_BITS-1:0]     i_wb_data,
    output logic                     o_wb_ready,
    output logic                     o_wb_done,
    input  logic [Addr_width-1:0]    i_chk_addr,
    output logic                     o_chk_hit,
    output logic                     o_awvalid,
    input  logic                     i_awready,
    output logic [Addr_width-1:0]    o_awaddr,
    output logic [7:0]               o_awlen,
    output logic [2:0]               o_awsize,
    output logic [1:0]               o_awburst,
    output logic                     o_wvalid,
    input  logic                     i_wready,
    output logic [Segment_width-1:0] o_wdata,
    output logic [3:0]               o_wstrb,
    output logic                     o_wlast,
    input  logic                     i_bvalid,
    output logic                     o_bready,
    output state_t                   o_dbg_state,
    output logic [CNT_W-1:0]         o_dbg_count
);

    localparam int BEATS = beat_count(Offset_len);
    localparam int TAG_W = Addr_width - Offset_len;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    // Handshakes: a transfer happens on a rising edge where valid && ready; the
    // sender holds payload stable while valid is high and ready is low.
    state_t                 r_state;
    state_t                 w_next_state;
    logic [LINE_BITS-1:0]   r_line;
    logic [TAG_W-1:0]       r_tag;
    logic [CNT_W-1:0]       r_count;
    logic                   w_accept;
    logic                   w_beat;
    logic                   w_unused_offset;

    assign w_accept = (r_state == ST_IDLE) && i_wb_req;
    assign w_beat   = (r_state == ST_W) && i_wready;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (i_wb_req)                       w_next_state = ST_AW;
            ST_AW:   if (i_awready)                      w_next_state = ST_W;
            ST_W:    if (i_wready && r_count == LAST_BEAT) w_next_state = ST_B;
            ST_B:    if (i_bvalid)                       w_next_state = ST_IDLE;
            default:                                     w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        o_wb_ready = 1'b0;
        o_awvalid  = 1'b0;
        o_wvalid   = 1'b0;
        o_wlast    = 1'b0;
        o_bready   = 1'b0;
        o_wb_done  = 1'b0;
        case (r_state)
            ST_IDLE: o_wb_ready = 1'b1;
            ST_AW:   o_awvalid  = 1'b1;
            ST_W: begin
                o_wvalid = 1'b1;
                o_wlast  = (r_count == LAST_BEAT);
            end
            ST_B: begin
                o_bready  = 1'b1;
                o_wb_done = i_bvalid;
            end
            default: o_wb_ready = 1'b0;
        endcase
    end

    // The counter saturates on the last beat; it is only re-armed by a new capture.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_line  <= '0;
            r_tag   <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_line  <= i_wb_data;
            r_tag   <= i_wb_addr[Addr_width-1:Offset_len];
            r_count <= '0;
        end else if (w_beat && r_count != LAST_BEAT) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    mux_write_data #(
        .LINE_BITS (LINE_BITS),
        .SEG_W     (Segment_width),
        .SEL_W     (CNT_W)
    ) u_mux_write_data (
        .i_line (r_line),
        .i_sel  (r_count),
        .o_data (o_wdata)
    );

    assign o_awaddr   = {r_tag, {Offset_len{1'b0}}};
    assign o_awlen    = 8'(BEATS - 1);
    assign o_awsize   = AXI_SIZE_4B;
    assign o_awburst  = AXI_BURST_INCR;
    assign o_wstrb    = AXI_STRB_FULL;
    assign o_chk_hit  = (r_state != ST_IDLE) && (i_chk_addr[Addr_width-1:Offset_len] == r_tag);

    assign o_dbg_state = r_state;
    assign o_dbg_count = r_count;

    // Offset bits select a byte within the line and play no part in matching.
    assign w_unused_offset = ^{i_wb_addr[Offset_len-1:0], i_chk_addr[Offset_len-1:0]};

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Directed bench for dcache_write_buffer: one linear sequence of steps with
// hand-computed expectations checked by immediate assertions.
module tb_dcache_write_buffer;
    import dcache_write_buffer_pkg::*;

    logic         clk = 1'b0;
    logic         rstn;
    logic         wb_req;
    logic [31:0]  wb_addr;
    logic [511:0] wb_data;
    logic         wb_ready;
    logic         wb_done;
    logic [31:0]  chk_addr;
    logic         chk_hit;
    logic         awvalid;
    logic         awready;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         wvalid;
    logic         wready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast;
    logic         bvalid;
    logic         bready;
    state_t       dbg_state;
    logic [4:0]   dbg_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dcache_write_buffer dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_wb_req    (wb_req),
        .i_wb_addr   (wb_addr),
        .i_wb_data   (wb_data),
        .o_wb_ready  (wb_ready),
        .o_wb_done   (wb_done),
        .i_chk_addr  (chk_addr),
        .o_chk_hit   (chk_hit),
        .o_awvalid   (awvalid),
        .i_awready   (awready),
        .o_awaddr    (awaddr),
        .o_awlen     (awlen),
        .o_awsize    (awsize),
        .o_awburst   (awburst),
        .o_wvalid    (wvalid),
        .i_wready    (wready),
        .o_wdata     (wdata),
        .o_wstrb     (wstrb),
        .o_wlast     (wlast),
        .i_bvalid    (bvalid),
        .o_bready    (bready),
        .o_dbg_state (dbg_state),
        .o_dbg_count (dbg_count)
    );

    function automatic logic [511:0] make_line(input logic [31:0] base);
        logic [511:0] line;
        for (int i = 0; i < 16; i++) begin
            line[i*32 +: 32] = base + 32'(i);
        end
        return line;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        int b;
        logic tog;

        rstn     = 1'b0;
        wb_req   = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;
        chk_addr = '0;
        awready  = 1'b0;
        wready   = 1'b0;
        bvalid   = 1'b0;

        // Reset and idle
        next_cycle();
        next_cycle();
        rstn = 1'b1;
        settle();
        check("rst_wb_ready", 64'(wb_ready), 64'd1);
        check("rst_wb_done", 64'(wb_done), 64'd0);
        check("rst_chk_hit", 64'(chk_hit), 64'd0);
        check("rst_awvalid", 64'(awvalid), 64'd0);
        check("rst_wvalid", 64'(wvalid), 64'd0);
        check("rst_wlast", 64'(wlast), 64'd0);
        check("rst_bready", 64'(bready), 64'd0);
        check("rst_awaddr", 64'(awaddr), 64'd0);
        check("rst_wdata", 64'(wdata), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));

        // Full-speed burst, capture in cycle t
        next_cycle();
        wb_req   = 1'b1;
        wb_addr  = 32'h1234_5678;
        wb_data  = make_line(32'hA000_0000);
        awready  = 1'b1;
        wready   = 1'b1;
        bvalid   = 1'b1;
        chk_addr = 32'h1234_567C;
        settle();
        check("fs_t_wb_ready", 64'(wb_ready), 64'd1);
        check("fs_t_chk_idle", 64'(chk_hit), 64'd0);

        next_cycle();
        wb_req = 1'b0;
        settle();
        check("fs_t1_awvalid", 64'(awvalid), 64'd1);
        check("fs_t1_awaddr", 64'(awaddr), 64'h1234_5640);
        check("fs_t1_awlen", 64'(awlen), 64'd15);
        check("fs_t1_awsize", 64'(awsize), 64'd2);
        check("fs_t1_awburst", 64'(awburst), 64'd1);
        check("fs_t1_wstrb", 64'(wstrb), 64'hF);
        check("fs_t1_wvalid", 64'(wvalid), 64'd0);
        check("fs_t1_wb_ready", 64'(wb_ready), 64'd0);
        check("fs_t1_chk_same_line", 64'(chk_hit), 64'd1);
        chk_addr = 32'h1234_5604;
        settle();
        check("fs_t1_chk_other_line", 64'(chk_hit), 64'd0);
        chk_addr = 32'h1234_5640;

        for (int i = 0; i < 16; i++) begin
            next_cycle();
            settle();
            check("fs_beat_wvalid", 64'(wvalid), 64'd1);
            check("fs_beat_awvalid", 64'(awvalid), 64'd0);
            check("fs_beat_wdata", 64'(wdata), 64'(32'hA000_0000 + 32'(i)));
            check("fs_beat_wlast", 64'(wlast), (i == 15) ? 64'd1 : 64'd0);
        end

        next_cycle();
        settle();
        check("fs_t18_bready", 64'(bready), 64'd1);
        check("fs_t18_wb_done", 64'(wb_done), 64'd1);
        check("fs_t18_wvalid", 64'(wvalid), 64'd0);

        next_cycle();
        settle();
        check("fs_t19_wb_ready", 64'(wb_ready), 64'd1);
        check("fs_t19_wb_done", 64'(wb_done), 64'd0);
        check("fs_t19_chk_hit", 64'(chk_hit), 64'd0);

        // Stalled burst: awready late, wready toggling, stray bvalid during AW
        next_cycle();
        wb_req  = 1'b1;
        wb_addr = 32'h1234_5610;
        wb_data = make_line(32'hB000_0000);
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b1;
        settle();
        check("st_t_wb_ready", 64'(wb_ready), 64'd1);

        next_cycle();
        wb_req   = 1'b0;
        chk_addr = 32'h1234_5604;
        settle();
        check("st_chk_hit_in_line", 64'(chk_hit), 64'd1);
        chk_addr = 32'h1234_5684;
        settle();
        check("st_chk_miss_next_line", 64'(chk_hit), 64'd0);
        chk_addr = 32'h1234_5604;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) next_cycle();
            settle();
            check("st_aw_awvalid", 64'(awvalid), 64'd1);
            check("st_aw_awaddr", 64'(awaddr), 64'h1234_5600);
            check("st_aw_wvalid", 64'(wvalid), 64'd0);
            check("st_aw_stray_bvalid", 64'(wb_done), 64'd0);
        end

        next_cycle();
        awready = 1'b1;
        bvalid  = 1'b0;
        settle();
        check("st_aw_accept_awvalid", 64'(awvalid), 64'd1);

        b   = 0;
        tog = 1'b1;
        for (int k = 0; k < 40 && b < 16; k++) begin
            next_cycle();
            wready = tog;
            settle();
            check("st_w_wvalid", 64'(wvalid), 64'd1);
            check("st_w_awvalid", 64'(awvalid), 64'd0);
            check("st_w_wdata", 64'(wdata), 64'(32'hB000_0000 + 32'(b)));
            check("st_w_wlast", 64'(wlast), (b == 15) ? 64'd1 : 64'd0);
            if (tog) b++;
            tog = ~tog;
        end
        check("st_beat_count", 64'(b), 64'd16);

        next_cycle();
        wready = 1'b0;
        settle();
        check("st_b_state", 64'(dbg_state), 64'(ST_B));
        check("st_b_wvalid", 64'(wvalid), 64'd0);
        check("st_b_bready", 64'(bready), 64'd1);
        check("st_b_wait_done", 64'(wb_done), 64'd0);

        next_cycle();
        bvalid = 1'b1;
        settle();
        check("st_b_wb_done", 64'(wb_done), 64'd1);
        check("st_b_chk_hit", 64'(chk_hit), 64'd1);

        next_cycle();
        bvalid = 1'b0;
        settle();
        check("st_after_done_chk_hit", 64'(chk_hit), 64'd0);
        check("st_after_done_wb_ready", 64'(wb_ready), 64'd1);

        // wb_req held through a drain: second line waits for IDLE
        next_cycle();
        wb_req   = 1'b1;
        wb_addr  = 32'h0000_1000;
        wb_data  = make_line(32'hC000_0000);
        awready  = 1'b1;
        wready   = 1'b1;
        bvalid   = 1'b1;
        chk_addr = 32'h0;
        settle();
        check("hold_t_wb_ready", 64'(wb_ready), 64'd1);

        next_cycle();
        wb_addr = 32'h0000_2040;
        wb_data = make_line(32'hD000_0000);
        settle();
        check("hold_t1_awaddr", 64'(awaddr), 64'h0000_1000);
        check("hold_t1_wb_ready", 64'(wb_ready), 64'd0);

        repeat (8) next_cycle();
        settle();
        check("hold_beat7_wdata", 64'(wdata), 64'hC000_0007);
        check("hold_beat7_awaddr", 64'(awaddr), 64'h0000_1000);

        repeat (10) next_cycle();
        settle();
        check("hold_t19_wb_ready", 64'(wb_ready), 64'd1);

        next_cycle();
        wb_req = 1'b0;
        settle();
        check("hold_second_awvalid", 64'(awvalid), 64'd1);
        check("hold_second_awaddr", 64'(awaddr), 64'h0000_2040);

        next_cycle();
        settle();
        check("hold_second_beat0", 64'(wdata), 64'hD000_0000);

        repeat (17) next_cycle();
        settle();
        check("hold_second_idle", 64'(wb_ready), 64'd1);

        // Reset during beat 7, then a fresh burst from word 0
        next_cycle();
        wb_req  = 1'b1;
        wb_addr = 32'h0000_3000;
        wb_data = make_line(32'hE000_0000);
        settle();

        next_cycle();
        wb_req = 1'b0;
        repeat (8) next_cycle();
        settle();
        check("rb_beat7_wdata", 64'(wdata), 64'hE000_0007);
        rstn = 1'b0;

        next_cycle();
        rstn = 1'b1;
        settle();
        check("rb_state", 64'(dbg_state), 64'(ST_IDLE));
        check("rb_wvalid", 64'(wvalid), 64'd0);
        check("rb_count", 64'(dbg_count), 64'd0);
        check("rb_wb_ready", 64'(wb_ready), 64'd1);
        check("rb_awaddr", 64'(awaddr), 64'd0);
        check("rb_wdata", 64'(wdata), 64'd0);

        next_cycle();
        wb_req  = 1'b1;
        wb_addr = 32'h0000_4000;
        wb_data = make_line(32'hF000_0000);
        settle();

        next_cycle();
        wb_req = 1'b0;
        settle();
        check("rb_new_awaddr", 64'(awaddr), 64'h0000_4000);

        for (int i = 0; i < 16; i++) begin
            next_cycle();
            settle();
            check("rb_new_wdata", 64'(wdata), 64'(32'hF000_0000 + 32'(i)));
            check("rb_new_wlast", 64'(wlast), (i == 15) ? 64'd1 : 64'd0);
        end

        next_cycle();
        settle();
        check("rb_new_wb_done", 64'(wb_done), 64'd1);

        next_cycle();
        settle();
        check("rb_new_idle", 64'(wb_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dcache_write_buffer.md
# dcache_write_buffer

Single-entry write-back buffer between the data cache and the AXI write channels. It captures one evicted dirty line (address plus 512-bit data) in a single cycle, then drains it to memory as a 16-beat, 32-bit INCR burst. It also reports whether a given line address matches the line still in flight, so the cache can stall a refill of the same line. Cache and buffer are sized by the same offset parameter.

## Interface
- Offset_len, 6: line offset bits; line = 1<<(Offset_len+3) bits, beats = 1<<(Offset_len-2)
- Segment_width, 32: beat width in bits
- Addr_width, 32: byte address width
- clk  in  1  single clock; all state updates on rising edge
- rstn  in  1  reset, synchronous, active-low
- wb_req  in  1  cache offers a dirty line
- wb_addr  in  Addr_width  line address; low Offset_len bits ignored
- wb_data  in  1<<(Offset_len+3)  line data, word 0 in bits [31:0]
- wb_ready  out  1  buffer empty; wb_req accepted this cycle when high
- wb_done  out  1  one-cycle pulse when the write response is received
- chk_addr  in  Addr_width  address to compare against the buffered line
- chk_hit  out  1  buffered line is in flight and its line address matches chk_addr
- awvalid, awready  out/in  1  address handshake
- awaddr  out  Addr_width  buffered line address with the offset field zeroed
- awlen  out  8  beats-1 (15); awsize out 3 = 3'b010; awburst out 2 = 2'b01
- wvalid, wready  out/in  1  data handshake
- wdata  out  Segment_width  current beat; wstrb out 4 = 4'hF; wlast out 1
- bvalid, bready  in/out  1  response handshake; bresp is not consumed

## Operation
- FSM states: IDLE, AW, W, B.
- IDLE: wb_ready=1. If wb_req is high, latch wb_addr (offset bits zeroed) and wb_data, clear buf_shift_count, and go to AW. While wb_ready=0, wb_req is ignored and the cache holds it.
- AW: awvalid=1 with awaddr stable. On awready go to W.
- W: wvalid=1, wdata = word buf_shift_count of the latched line. On each wvalid&&wready, buf_shift_count increments. wlast=1 when buf_shift_count==beats-1. When the last beat handshakes, go to B.
- B: bready=1. On bvalid, pulse wb_done and go to IDLE.
- buf_shift_count is Offset_len-1 bits wide. It never wraps past beats-1 within a burst.
- chk_hit = (state!=IDLE) && chk_addr[Addr_width-1:Offset_len]==line tag. It is combinational.
- When wready is low, wdata and wlast stay stable and the counter holds.
- Reset in any state: go to IDLE, drop the line, clear the counter, deassert all valids and ready strobes.

## Timing
- Reset values: wb_ready=1. wb_done, chk_hit, awvalid, wvalid, wlast and bready are all 0. awaddr=0, wdata=word 0 of the cleared buffer (0).
- Acceptance cycle t: awvalid=1 at t+1.
- With awready, wready and bvalid held high, the beats occupy t+2..t+17, wlast is high at t+17, bready and wb_done are high at t+18, and wb_ready=1 at t+19.
- awvalid and wvalid never assert together, so there is no write-data-before-address.
- bvalid that arrives outside B is ignored.

## Structure
- Shared package: state enum, AXI constants (INCR burst, size 4 bytes, full strobe), and derived widths (line bits, beat count, counter width).
- Instantiate the existing word-select mux mux_write_data with buf_shift_count and the latched line to produce wdata. The FSM, counter and address latch live in this module.

## Test plan
- Reset, then idle: wb_ready=1, all AXI valids 0, chk_hit=0.
- wb_addr=0x1234_5678 with word i = 0xA000_0000+i, and all slaves always ready. Required: awaddr=0x1234_5640, awlen=15, 16 beats 0xA000_0000..0xA000_000F in order, wlast only on beat 16, wb_ready back at t+19.
- wready toggles 1,0,1,0 and awready is delayed 3 cycles. Required: wdata and wlast hold during stalls, exactly 16 beats, awvalid held until accepted.
- Line in flight: chk_addr=0x1234_5604 gives chk_hit=1. chk_addr=0x1234_5684 gives 0. After wb_done, chk_hit=0.
- wb_req held during a drain: no second capture until IDLE. The second line is captured on the first wb_ready cycle.
- rstn low at beat 7: next cycle in IDLE, wvalid=0, counter 0. A following new request bursts from word 0.
